ts3d_core: RTL and testbench

- Sparse-convolution compute core: five global buffers (weights, weight flags, activations, activation flags, activation valid-numbers) feed a sequential MAC engine.
- The engine produces NUMPEB × LENPSUM partial sums (psums) and stores them in a psum bank.
- The pooling stage reads psums back through a one-hot PE-block select.

---
 rtl/ts3d_core.sv | 258 +++++++++++++++++++++++++
 tb/tb_ts3d_core.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ts3d_core.sv
// ts3d_core: sparse-convolution compute core.
//   Five global buffers (weights, weight flags, activations, activation flags,
//   activation nonzero counts) feed a three-stage MAC pipeline:
//     stage 0: p/i/c counters, flag and VN buffer reads
//     stage 1: compressed-index computation (prefix popcount), data reads
//     stage 2: signed multiply-accumulate, commit to the psum bank
//   A one-hot PE-block select reads psums back into the pooled output vector.
// Ports:
//   clk, rst_n            clock / synchronous reset (active high)
//   POOLPEB_EnRd/AddrRd   psum read select (lowest set bit picks the PE block)
//   GBF*_Val/EnWr/AddrWr/DatWr  buffer write ports, write when Val && EnWr
//   PELPOOL_Dat           LENPSUM psum slots, slot k at [k*PSUM_WIDTH +: PSUM_WIDTH]
module ts3d_core #(
  parameter int DATA_WIDTH          = 8,
  parameter int BLOCK_DEPTH         = 32,
  parameter int CHANNEL_DEPTH       = 32,
  parameter int NUMPEB              = 4,
  parameter int LENPSUM             = 4,
  parameter int GBFWEI_ADDRWIDTH    = 7,
  parameter int GBFWEI_DATAWIDTH    = DATA_WIDTH,
  parameter int GBFFLGWEI_DATAWIDTH = BLOCK_DEPTH,
  parameter int GBFACT_ADDRWIDTH    = 7,
  parameter int PSUM_WIDTH          = 2*DATA_WIDTH + $clog2(CHANNEL_DEPTH) + 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUMPEB-1:0]                POOLPEB_EnRd,
  input  logic [$clog2(LENPSUM)-1:0]       POOLPEB_AddrRd,
  input  logic                             GBFWEI_Val,
  input  logic                             GBFWEI_EnWr,
  input  logic [GBFWEI_ADDRWIDTH-1:0]      GBFWEI_AddrWr,
  input  logic [GBFWEI_DATAWIDTH-1:0]      GBFWEI_DatWr,
  input  logic                             GBFFLGWEI_Val,
  input  logic                             GBFFLGWEI_EnWr,
  input  logic [GBFWEI_ADDRWIDTH-1:0]      GBFFLGWEI_AddrWr,
  input  logic [GBFFLGWEI_DATAWIDTH-1:0]   GBFFLGWEI_DatWr,
  input  logic                             GBFACT_Val,
  input  logic                             GBFACT_EnWr,
  input  logic [GBFACT_ADDRWIDTH-1:0]      GBFACT_AddrWr,
  input  logic [DATA_WIDTH-1:0]            GBFACT_DatWr,
  input  logic                             GBFFLGACT_Val,
  input  logic                             GBFFLGACT_EnWr,
  input  logic [GBFACT_ADDRWIDTH-1:0]      GBFFLGACT_AddrWr,
  input  logic [BLOCK_DEPTH-1:0]           GBFFLGACT_DatWr,
  input  logic                             GBFVNACT_Val,
  input  logic                             GBFVNACT_EnWr,
  input  logic [GBFACT_ADDRWIDTH-1:0]      GBFVNACT_AddrWr,
  input  logic [$clog2(BLOCK_DEPTH)-1:0]   GBFVNACT_DatWr,
  output logic [PSUM_WIDTH*LENPSUM-1:0]    PELPOOL_Dat
);

  localparam int PB_W   = $clog2(NUMPEB);
  localparam int PS_W   = $clog2(LENPSUM);
  localparam int CH_W   = $clog2(BLOCK_DEPTH);
  localparam int CNT_W  = CH_W + 1;
  localparam int PROD_W = DATA_WIDTH + GBFWEI_DATAWIDTH;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t stateReg, stateNext;
  logic   dirtyReg, issue, startPass, lastCommit;

  // Buffers (no reset: contents survive rst_n)
  logic [GBFWEI_DATAWIDTH-1:0]    weiMem    [2**GBFWEI_ADDRWIDTH];
  logic [GBFFLGWEI_DATAWIDTH-1:0] flgWeiMem [2**GBFWEI_ADDRWIDTH];
  logic [DATA_WIDTH-1:0]          actMem    [2**GBFACT_ADDRWIDTH];
  logic [BLOCK_DEPTH-1:0]         flgActMem [2**GBFACT_ADDRWIDTH];
  logic [CH_W-1:0]                vnMem     [2**GBFACT_ADDRWIDTH];

  // Stage 0
  logic [PB_W-1:0] cntP;
  logic [PS_W-1:0] cntI;
  logic [CH_W-1:0] cntC;
  logic            issuedAll;
  // Stage 1
  logic                           s1Valid;
  logic [PB_W-1:0]                s1P;
  logic [PS_W-1:0]                s1I;
  logic [CH_W-1:0]                s1C;
  logic [BLOCK_DEPTH-1:0]         flgActRd;
  logic [GBFFLGWEI_DATAWIDTH-1:0] flgWeiRd;
  logic [CH_W-1:0]                vnRd;
  logic [GBFACT_ADDRWIDTH-1:0]    baseReg, actIdx;
  logic [GBFWEI_ADDRWIDTH-1:0]    weiIdx;
  logic [BLOCK_DEPTH-1:0]         lowMask;
  logic [CNT_W-1:0]               actCnt, weiCnt;
  logic                           gate;
  // Stage 2
  logic                               s2Valid, s2Gate;
  logic [PB_W-1:0]                    s2P;
  logic [PS_W-1:0]                    s2I;
  logic [CH_W-1:0]                    s2C;
  logic signed [DATA_WIDTH-1:0]       actRd;
  logic signed [GBFWEI_DATAWIDTH-1:0] weiRd;
  logic signed [PROD_W-1:0]           prod;
  logic signed [PSUM_WIDTH-1:0]       prodExt, accReg, accNext;
  logic signed [PSUM_WIDTH-1:0]       bank [NUMPEB][LENPSUM];
  // Read path
  logic [PB_W-1:0]              selP;
  logic signed [PSUM_WIDTH-1:0] rdWord;
  logic signed [PSUM_WIDTH-1:0] slotReg [LENPSUM];

  wire anyWr  = (GBFWEI_Val & GBFWEI_EnWr) | (GBFFLGWEI_Val & GBFFLGWEI_EnWr) |
                (GBFACT_Val & GBFACT_EnWr) | (GBFFLGACT_Val & GBFFLGACT_EnWr) |
                (GBFVNACT_Val & GBFVNACT_EnWr);
  wire allVal = GBFWEI_Val & GBFFLGWEI_Val & GBFACT_Val & GBFFLGACT_Val & GBFVNACT_Val;
  wire anyEn  = GBFWEI_EnWr | GBFFLGWEI_EnWr | GBFACT_EnWr | GBFFLGACT_EnWr | GBFVNACT_EnWr;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (rst_n) stateReg <= IDLE;
    else       stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (dirtyReg && allVal && !anyEn) stateNext = COMPUTE;
      COMPUTE: if (lastCommit) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    issue     = 1'b0;
    startPass = 1'b0;
    case (stateReg)
      IDLE:    startPass = (stateNext == COMPUTE);
      COMPUTE: issue     = !issuedAll;
      default: ;
    endcase
  end

  // Writes accepted mid-pass leave dirty set, so a fresh pass follows DONE.
  always_ff @(posedge clk) begin
    if (rst_n)          dirtyReg <= 1'b0;
    else if (startPass) dirtyReg <= 1'b0;
    else if (anyWr)     dirtyReg <= 1'b1;
  end

  // ---------------- buffers with registered reads ----------------
  always_ff @(posedge clk) begin
    if (GBFWEI_Val && GBFWEI_EnWr) weiMem[GBFWEI_AddrWr] <= GBFWEI_DatWr;
    weiRd <= weiMem[weiIdx];
  end
  always_ff @(posedge clk) begin
    if (GBFFLGWEI_Val && GBFFLGWEI_EnWr) flgWeiMem[GBFFLGWEI_AddrWr] <= GBFFLGWEI_DatWr;
    flgWeiRd <= flgWeiMem[GBFWEI_ADDRWIDTH'(cntP)];
  end
  always_ff @(posedge clk) begin
    if (GBFACT_Val && GBFACT_EnWr) actMem[GBFACT_AddrWr] <= GBFACT_DatWr;
    actRd <= actMem[actIdx];
  end
  always_ff @(posedge clk) begin
    if (GBFFLGACT_Val && GBFFLGACT_EnWr) flgActMem[GBFFLGACT_AddrWr] <= GBFFLGACT_DatWr;
    flgActRd <= flgActMem[GBFACT_ADDRWIDTH'(cntI)];
  end
  always_ff @(posedge clk) begin
    if (GBFVNACT_Val && GBFVNACT_EnWr) vnMem[GBFVNACT_AddrWr] <= GBFVNACT_DatWr;
    vnRd <= vnMem[GBFACT_ADDRWIDTH'(cntI)];
  end

  // ---------------- stage 0: p outer, i middle, c inner ----------------
  always_ff @(posedge clk) begin
    if (rst_n || startPass) begin
      cntP <= '0; cntI <= '0; cntC <= '0; issuedAll <= 1'b0;
    end else if (issue) begin
      cntC <= cntC + 1'b1;
      if (cntC == CH_W'(BLOCK_DEPTH-1)) begin
        cntI <= cntI + 1'b1;
        if (cntI == PS_W'(LENPSUM-1)) begin
          cntP <= cntP + 1'b1;
          if (cntP == PB_W'(NUMPEB-1)) issuedAll <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      s1Valid <= 1'b0; s1P <= '0; s1I <= '0; s1C <= '0;
    end else begin
      s1Valid <= issue; s1P <= cntP; s1I <= cntI; s1C <= cntC;
    end
  end

  // ---------------- stage 1: compressed indices ----------------
  // Data index = block base + number of nonzero channels below c.
  always_comb begin
    lowMask = (BLOCK_DEPTH'(1) << s1C) - BLOCK_DEPTH'(1);
    actCnt  = '0;
    weiCnt  = '0;
    for (int b = 0; b < BLOCK_DEPTH; b++) begin
      actCnt += CNT_W'(flgActRd[b] & lowMask[b]);
      weiCnt += CNT_W'(flgWeiRd[b] & lowMask[b]);
    end
    actIdx = baseReg + GBFACT_ADDRWIDTH'(actCnt);
    weiIdx = (GBFWEI_ADDRWIDTH'(s1P) << CH_W) + GBFWEI_ADDRWIDTH'(weiCnt);
    gate   = flgActRd[s1C] & flgWeiRd[s1C];
  end

  // Activation block base: running sum of VN over the blocks already walked
  // for the current p; restarts at 0 when i wraps.
  always_ff @(posedge clk) begin
    if (rst_n || startPass) baseReg <= '0;
    else if (s1Valid && s1C == CH_W'(BLOCK_DEPTH-1)) begin
      if (s1I == PS_W'(LENPSUM-1)) baseReg <= '0;
      else                         baseReg <= baseReg + GBFACT_ADDRWIDTH'(vnRd);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      s2Valid <= 1'b0; s2Gate <= 1'b0; s2P <= '0; s2I <= '0; s2C <= '0;
    end else begin
      s2Valid <= s1Valid; s2Gate <= gate; s2P <= s1P; s2I <= s1I; s2C <= s1C;
    end
  end

  // ---------------- stage 2: MAC and commit ----------------
  always_comb begin
    prod       = $signed(actRd) * $signed(weiRd);
    prodExt    = {{(PSUM_WIDTH-PROD_W){prod[PROD_W-1]}}, prod};
    accNext    = ((s2C == '0) ? '0 : accReg) + (s2Gate ? prodExt : '0);
    lastCommit = s2Valid && (s2C == CH_W'(BLOCK_DEPTH-1)) &&
                 (s2P == PB_W'(NUMPEB-1)) && (s2I == PS_W'(LENPSUM-1));
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      accReg <= '0;
      for (int p = 0; p < NUMPEB; p++)
        for (int i = 0; i < LENPSUM; i++)
          bank[p][i] <= '0;
    end else if (s2Valid) begin
      accReg <= accNext;
      if (s2C == CH_W'(BLOCK_DEPTH-1)) bank[s2P][s2I] <= accNext;
    end
  end

  // ---------------- read path ----------------
  always_comb begin
    selP = '0;
    for (int k = NUMPEB-1; k >= 0; k--)
      if (POOLPEB_EnRd[k]) selP = PB_W'(k);
    rdWord = bank[selP][POOLPEB_AddrRd];
  end

  for (genvar gi = 0; gi < LENPSUM; gi++) begin : gSlot
    always_ff @(posedge clk) begin
      if (rst_n) slotReg[gi] <= '0;
      else if (|POOLPEB_EnRd && POOLPEB_AddrRd == PS_W'(gi)) slotReg[gi] <= rdWord;
    end
    assign PELPOOL_Dat[gi*PSUM_WIDTH +: PSUM_WIDTH] = slotReg[gi];
  end

endmodule

// File: tb/tb_ts3d_core.sv
// tb_ts3d_core: directed-vector bench for ts3d_core. Loads buffers through
// the write ports, lets the core run its pass, reads psums back through the
// pooling port and compares each slot against hand-computed values.
module tb_ts3d_core;
  localparam int PW = 23;
  localparam int SEL_WEI = 0, SEL_FWEI = 1, SEL_ACT = 2, SEL_FACT = 3, SEL_VN = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [3:0]    POOLPEB_EnRd;
  logic [1:0]    POOLPEB_AddrRd;
  logic          GBFWEI_Val, GBFWEI_EnWr;
  logic [6:0]    GBFWEI_AddrWr;
  logic [7:0]    GBFWEI_DatWr;
  logic          GBFFLGWEI_Val, GBFFLGWEI_EnWr;
  logic [6:0]    GBFFLGWEI_AddrWr;
  logic [31:0]   GBFFLGWEI_DatWr;
  logic          GBFACT_Val, GBFACT_EnWr;
  logic [6:0]    GBFACT_AddrWr;
  logic [7:0]    GBFACT_DatWr;
  logic          GBFFLGACT_Val, GBFFLGACT_EnWr;
  logic [6:0]    GBFFLGACT_AddrWr;
  logic [31:0]   GBFFLGACT_DatWr;
  logic          GBFVNACT_Val, GBFVNACT_EnWr;
  logic [6:0]    GBFVNACT_AddrWr;
  logic [4:0]    GBFVNACT_DatWr;
  logic [PW*4-1:0] PELPOOL_Dat;

  ts3d_core dut (
    .clk(clk), .rst_n(rst_n),
    .POOLPEB_EnRd(POOLPEB_EnRd), .POOLPEB_AddrRd(POOLPEB_AddrRd),
    .GBFWEI_Val(GBFWEI_Val), .GBFWEI_EnWr(GBFWEI_EnWr),
    .GBFWEI_AddrWr(GBFWEI_AddrWr), .GBFWEI_DatWr(GBFWEI_DatWr),
    .GBFFLGWEI_Val(GBFFLGWEI_Val), .GBFFLGWEI_EnWr(GBFFLGWEI_EnWr),
    .GBFFLGWEI_AddrWr(GBFFLGWEI_AddrWr), .GBFFLGWEI_DatWr(GBFFLGWEI_DatWr),
    .GBFACT_Val(GBFACT_Val), .GBFACT_EnWr(GBFACT_EnWr),
    .GBFACT_AddrWr(GBFACT_AddrWr), .GBFACT_DatWr(GBFACT_DatWr),
    .GBFFLGACT_Val(GBFFLGACT_Val), .GBFFLGACT_EnWr(GBFFLGACT_EnWr),
    .GBFFLGACT_AddrWr(GBFFLGACT_AddrWr), .GBFFLGACT_DatWr(GBFFLGACT_DatWr),
    .GBFVNACT_Val(GBFVNACT_Val), .GBFVNACT_EnWr(GBFVNACT_EnWr),
    .GBFVNACT_AddrWr(GBFVNACT_AddrWr), .GBFVNACT_DatWr(GBFVNACT_DatWr),
    .PELPOOL_Dat(PELPOOL_Dat)
  );

  int vecCnt  = 0;
  int missCnt = 0;

  task automatic chkVal(input string tag, input int got, input int exp);
    vecCnt++;
    if (got !== exp) begin
      missCnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  function automatic int slotVal(input int k);
    logic signed [PW-1:0] v;
    v = PELPOOL_Dat[k*PW +: PW];
    return int'(v);
  endfunction

  // One write per call; starts and ends on a falling edge so back-to-back
  // calls keep EnWr high without a gap.
  task automatic wrBuf(input int sel, input int addr, input int dat);
    case (sel)
      SEL_WEI:  begin GBFWEI_EnWr = 1'b1;    GBFWEI_AddrWr = 7'(addr);    GBFWEI_DatWr = 8'(dat); end
      SEL_FWEI: begin GBFFLGWEI_EnWr = 1'b1; GBFFLGWEI_AddrWr = 7'(addr); GBFFLGWEI_DatWr = 32'(dat); end
      SEL_ACT:  begin GBFACT_EnWr = 1'b1;    GBFACT_AddrWr = 7'(addr);    GBFACT_DatWr = 8'(dat); end
      SEL_FACT: begin GBFFLGACT_EnWr = 1'b1; GBFFLGACT_AddrWr = 7'(addr); GBFFLGACT_DatWr = 32'(dat); end
      default:  begin GBFVNACT_EnWr = 1'b1;  GBFVNACT_AddrWr = 7'(addr);  GBFVNACT_DatWr = 5'(dat); end
    endcase
    @(negedge clk);
    GBFWEI_EnWr = 1'b0; GBFFLGWEI_EnWr = 1'b0; GBFACT_EnWr = 1'b0;
    GBFFLGACT_EnWr = 1'b0; GBFVNACT_EnWr = 1'b0;
  endtask

  task automatic rdPsum(input int en, input int addr);
    POOLPEB_EnRd = 4'(en);
    POOLPEB_AddrRd = 2'(addr);
    @(negedge clk);
    POOLPEB_EnRd = 4'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1;
    POOLPEB_EnRd = '0; POOLPEB_AddrRd = '0;
    GBFWEI_Val = 0; GBFWEI_EnWr = 0; GBFWEI_AddrWr = '0; GBFWEI_DatWr = '0;
    GBFFLGWEI_Val = 0; GBFFLGWEI_EnWr = 0; GBFFLGWEI_AddrWr = '0; GBFFLGWEI_DatWr = '0;
    GBFACT_Val = 0; GBFACT_EnWr = 0; GBFACT_AddrWr = '0; GBFACT_DatWr = '0;
    GBFFLGACT_Val = 0; GBFFLGACT_EnWr = 0; GBFFLGACT_AddrWr = '0; GBFFLGACT_DatWr = '0;
    GBFVNACT_Val = 0; GBFVNACT_EnWr = 0; GBFVNACT_AddrWr = '0; GBFVNACT_DatWr = '0;
    idle(10);
    rst_n = 1'b0;
    GBFWEI_Val = 1; GBFFLGWEI_Val = 1; GBFACT_Val = 1; GBFFLGACT_Val = 1; GBFVNACT_Val = 1;
    idle(2);

    // Reset state
    for (int k = 0; k < 4; k++) chkVal($sformatf("reset slot%0d", k), slotVal(k), 0);
    rdPsum(1, 0);
    chkVal("reset bank p0 i0", slotVal(0), 0);

    // Dense: all flags set, acts 1, weights per block 2/-1/0/1 -> psum = 32*w
    for (int a = 0; a < 4; a++) begin
      wrBuf(SEL_FACT, a, 32'hFFFF_FFFF);
      wrBuf(SEL_FWEI, a, 32'hFFFF_FFFF);
      wrBuf(SEL_VN, a, 0);
    end
    for (int a = 0; a < 32; a++) wrBuf(SEL_ACT, a, 1);
    for (int a = 0; a < 128; a++) wrBuf(SEL_WEI, a, (a < 32) ? 2 : (a < 64) ? -1 : (a < 96) ? 0 : 1);
    idle(600);
    rdPsum(4'b0001, 0); chkVal("dense p0 i0 slot0", slotVal(0), 64);
    rdPsum(4'b0110, 1); chkVal("sel 0110 -> p1 slot1", slotVal(1), -32);
    rdPsum(4'b1000, 2); chkVal("sel 1000 -> p3 slot2", slotVal(2), 32);
    rdPsum(4'b0000, 3);
    chkVal("enrd 0 hold slot3", slotVal(3), 0);
    chkVal("enrd 0 hold slot0", slotVal(0), 64);
    rdPsum(4'b1010, 3); chkVal("sel 1010 -> p1 slot3", slotVal(3), -32);
    rdPsum(4'b0100, 0); chkVal("dense p2 i0 slot0", slotVal(0), 0);

    // Sparse alignment: only channel 2 matches for (0,0)
    wrBuf(SEL_FACT, 0, 5);
    wrBuf(SEL_VN, 0, 2);
    wrBuf(SEL_ACT, 0, 3);
    wrBuf(SEL_ACT, 1, -4);
    wrBuf(SEL_FWEI, 0, 4);
    wrBuf(SEL_WEI, 0, 5);
    idle(600);
    rdPsum(4'b0001, 0); chkVal("sparse p0 i0", slotVal(0), -20);
    rdPsum(4'b0010, 0); chkVal("sparse p1 i0 (3*-1 + -4*-1)", slotVal(0), 1);

    // Block base: block 1 starts at VN[0]=3
    wrBuf(SEL_VN, 0, 3);
    wrBuf(SEL_FACT, 1, 1);
    wrBuf(SEL_ACT, 3, 7);
    wrBuf(SEL_FWEI, 2, 1);
    wrBuf(SEL_WEI, 64, -2);
    idle(600);
    rdPsum(4'b0100, 1); chkVal("base p2 i1 slot1", slotVal(1), -14);
    rdPsum(4'b0100, 0); chkVal("base p2 i0 slot0", slotVal(0), -6);
    rdPsum(4'b0001, 0); chkVal("base p0 i0 unchanged", slotVal(0), -20);

    // Gating: EnWr with Val low is dropped
    GBFWEI_Val = 1'b0;
    wrBuf(SEL_WEI, 64, 10);
    GBFWEI_Val = 1'b1;
    idle(20);
    wrBuf(SEL_VN, 3, 0);
    idle(600);
    rdPsum(4'b0100, 1); chkVal("gated write ignored", slotVal(1), -14);

    // Retrigger: write mid-pass -> pass finishes, then a second pass runs
    wrBuf(SEL_WEI, 64, 4);
    idle(100);
    rdPsum(4'b0100, 1); chkVal("mid-pass read old value", slotVal(1), -14);
    idle(348);
    wrBuf(SEL_ACT, 3, -5);
    idle(110);
    rdPsum(4'b0100, 1); chkVal("first pass result", slotVal(1), 28);
    idle(700);
    rdPsum(4'b0100, 1); chkVal("second pass result", slotVal(1), -20);
    rdPsum(4'b0001, 0); chkVal("pre-reset slot0", slotVal(0), -20);

    // Mid-pass reset
    wrBuf(SEL_VN, 3, 0);
    idle(50);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) chkVal($sformatf("mid-pass reset slot%0d", k), slotVal(k), 0);
    rst_n = 1'b0;
    idle(600);
    rdPsum(4'b0001, 0); chkVal("bank cleared, no pass p0 i0", slotVal(0), 0);
    rdPsum(4'b0100, 1); chkVal("bank cleared, no pass p2 i1", slotVal(1), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
    $finish;
  end
endmodule
